smallckt_mc_datapath: RTL and testbench

- Parametrised successor to the single-cycle register-file/ALU/memory circuit.
- A multi-cycle sequencer latches every control input on a start handshake, so control changes never race the clock edge.
- Sequences operand read, ALU, data memory and register writeback, then pulses done.
- Sits between the test/control driver and the register file, ALU and data memory as the team's processor datapath core.

---
 rtl/smallckt_pkg.sv | 34 +++
 rtl/smallckt_alu.sv | 57 +++++
 rtl/smallckt_mc_datapath.sv | 196 +++++++++++++++++++
 tb/tb_smallckt_mc_datapath.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smallckt_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU opcodes, sequencer states
// and default widths.
package smallckt_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NREGS     = 32;
    localparam int DEF_MEM_DEPTH = 64;
    localparam int DEF_ALUC_W    = 5;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic is_addsub(input int op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/smallckt_alu.sv
// Combinational ALU for the multi-cycle datapath; produces the result and the
// signed-overflow indication for ADD/SUB.
module smallckt_alu
    import smallckt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ALUC_W = DEF_ALUC_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [ALUC_W-1:0] i_aluc,
    output logic [DATA_W-1:0] o_result,
    output logic              o_overflow
);

    localparam int MSB = DATA_W - 1;

    logic        [DATA_W-1:0] w_sum;
    logic        [DATA_W-1:0] w_diff;
    logic signed [DATA_W-1:0] w_as;
    logic signed [DATA_W-1:0] w_bs;
    logic        [4:0]        w_shamt;
    int                       w_op;

    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_as    = i_a;
    assign w_bs    = i_b;
    assign w_shamt = i_b[4:0];
    assign w_op    = int'(i_aluc);

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (w_op)
            ALU_ADD:  o_result = w_sum;
            ALU_SUB:  o_result = w_diff;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = w_as >>> w_shamt;
            ALU_SLT:  o_result = DATA_W'(w_as < w_bs);
            ALU_SLTU: o_result = DATA_W'(i_a < i_b);
            default:  o_result = '0;
        endcase
        // Overflow: operands agree in sign (ADD) or differ (SUB) and the result flips it.
        if (is_addsub(w_op)) begin
            if (w_op == ALU_ADD)
                o_overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            else
                o_overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
        end
    end

endmodule

// File: rtl/smallckt_mc_datapath.sv
// Multi-cycle register-file / ALU / data-memory datapath core.
// Optional macro SMALLCKT_ALU_FLAGS_EN adds the flags[1:0] = {overflow, zero} output.
module smallckt_mc_datapath
    import smallckt_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int NREGS     = DEF_NREGS,
    parameter  int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter  int ALUC_W    = DEF_ALUC_W,
    localparam int RA_W      = $clog2(NREGS),
    localparam int MA_W      = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic [ALUC_W-1:0] aluc,
    input  logic              regw,
    input  logic              memw,
    input  logic              memr,
    input  logic              init_we,
    input  logic [RA_W-1:0]   init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
`ifdef SMALLCKT_ALU_FLAGS_EN
    ,
    output logic [1:0]        flags
`endif
);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [RA_W-1:0]     r_rs1;
    logic [RA_W-1:0]     r_rs2;
    logic [RA_W-1:0]     r_rd;
    logic [ALUC_W-1:0]   r_aluc;
    logic                r_regw;
    logic                r_memw;
    logic                r_memr;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_alu;
    logic [DATA_W-1:0]   r_ldata;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_rf  [NREGS];
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic [DATA_W-1:0]   w_alu;
    logic                w_ovf;
    logic [DATA_W-1:0]   w_wb;
    logic [MA_W-1:0]     w_maddr;
    logic                w_init_hit;
    logic                w_wb_hit;

    smallckt_alu #(
        .DATA_W (DATA_W),
        .ALUC_W (ALUC_W)
    ) u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_aluc     (r_aluc),
        .o_result   (w_alu),
        .o_overflow (w_ovf)
    );

    assign w_maddr    = r_a[MA_W-1:0];
    assign w_wb       = r_memr ? r_ldata : r_alu;
    assign w_init_hit = (r_state == ST_IDLE) && init_we && (init_addr != '0);
    assign w_wb_hit   = (r_state == ST_WB) && r_regw && (r_rd != '0);

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

    // Sequencer: latches the whole command on the start edge, then walks one state per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_aluc  <= '0;
            r_regw  <= 1'b0;
            r_memw  <= 1'b0;
            r_memr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rs1   <= rs1;
                        r_rs2   <= rs2;
                        r_rd    <= rd;
                        r_aluc  <= aluc;
                        r_regw  <= regw;
                        r_memw  <= memw;
                        r_memr  <= memr;
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC:  r_state <= ST_MEM;
                ST_MEM:   r_state <= ST_WB;
                ST_WB: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand, ALU and load-data staging registers; only meaningful inside a sequence.
    always_ff @(posedge clk) begin
        case (r_state)
            ST_FETCH: begin
                r_a <= (r_rs1 == '0) ? '0 : r_rf[r_rs1];
                r_b <= (r_rs2 == '0) ? '0 : r_rf[r_rs2];
            end
            ST_EXEC: r_alu <= w_alu;
            ST_MEM: begin
                if (r_memr)
                    r_ldata <= r_mem[w_maddr];
            end
            default: ;
        endcase
    end

    // Register file: direct init writes in IDLE, writeback in WB; R0 never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_rf[i] <= '0;
        end else if (w_init_hit) begin
            r_rf[init_addr] <= init_data;
        end else if (w_wb_hit) begin
            r_rf[r_rd] <= w_wb;
        end
    end

    // Data memory; the load in the same MEM cycle sees the pre-store word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                r_mem[i] <= '0;
        end else if ((r_state == ST_MEM) && r_memw) begin
            r_mem[w_maddr] <= r_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_dout <= '0;
        else if (r_state == ST_WB)
            r_dout <= w_wb;
    end

`ifdef SMALLCKT_ALU_FLAGS_EN
    logic       r_ovf;
    logic [1:0] r_flags;

    always_ff @(posedge clk) begin
        if (r_state == ST_EXEC)
            r_ovf <= w_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= 2'b00;
        else if (r_state == ST_WB)
            r_flags <= {r_ovf, (w_wb == '0)};
    end

    assign flags = r_flags;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_ovf;
`endif

endmodule

// File: tb/tb_smallckt_mc_datapath.sv
// Scoreboard bench for smallckt_mc_datapath: directed plan plus randomized
// commands against a behavioural model of registers and memory.
module tb_smallckt_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  rs1, rs2, rd, aluc;
    logic        regw, memw, memr;
    logic        init_we;
    logic [4:0]  init_addr;
    logic [31:0] init_data;
    logic        busy, done;
    logic [31:0] dout;
`ifdef SMALLCKT_ALU_FLAGS_EN
    logic [1:0]  flags;
`endif

    smallckt_mc_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .aluc      (aluc),
        .regw      (regw),
        .memw      (memw),
        .memr      (memr),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .busy      (busy),
        .done      (done),
        .dout      (dout)
`ifdef SMALLCKT_ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] dout;
        logic [1:0]  flags;
        int          issue;
        string       tag;
    } exp_t;

    exp_t q[$];

    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int     sh = int'(b[4:0]);
        longint sa = longint'(int'(a));
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return 32'(sa >>> sh);
            8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        longint lim = 64'sh80000000;
        if (op == 0)      s = longint'(int'(a)) + longint'(int'(b));
        else if (op == 1) s = longint'(int'(a)) - longint'(int'(b));
        else              return 1'b0;
        return (s >= lim) || (s < -lim);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    endtask

    task automatic model_op(input int r1, input int r2, input int rdst, input int op,
                            input bit rw, input bit mw, input bit mr,
                            output logic [31:0] wb, output logic [1:0] fl);
        logic [31:0] a, b, alu, ld;
        int          addr;
        a    = (r1 == 0) ? 32'd0 : m_rf[r1];
        b    = (r2 == 0) ? 32'd0 : m_rf[r2];
        alu  = ref_alu(op, a, b);
        addr = int'(a % 64);
        ld   = m_mem[addr];
        if (mw) m_mem[addr] = b;
        wb = mr ? ld : alu;
        if (rw && rdst != 0) m_rf[rdst] = wb;
        fl = {ref_ovf(op, a, b), (wb == 32'd0)};
    endtask

    task automatic scramble();
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom); aluc = 5'($urandom);
        regw = 1'($urandom); memw = 1'($urandom); memr = 1'($urandom);
    endtask

    task automatic init_write(input int a, input logic [31:0] d);
        init_we = 1'b1; init_addr = 5'(a); init_data = d;
        @(negedge clk);
        init_we = 1'b0;
        if (a != 0) m_rf[a] = d;
    endtask

    // mode: 0 normal, 1 poke start+init_we during EXEC, 2 reset during MEM
    task automatic do_op(input string tag, input int r1, input int r2, input int rdst, input int op,
                         input bit rw, input bit mw, input bit mr, input int mode,
                         input bit ien, input int ia, input logic [31:0] idat);
        logic [31:0] wb;
        logic [1:0]  fl;
        exp_t        e;
        int          nb = 0;
        rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(rdst); aluc = 5'(op);
        regw = rw; memw = mw; memr = mr;
        init_we = ien; init_addr = 5'(ia); init_data = idat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; init_we = 1'b0;
        scramble();
        if (ien && ia != 0) m_rf[ia] = idat;
        if (mode != 2) begin
            model_op(r1, r2, rdst, op, rw, mw, mr, wb, fl);
            e.dout = wb; e.flags = fl; e.issue = cyc; e.tag = tag;
            q.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (mode == 1 && k == 1) begin
                start = 1'b1; init_we = 1'b1; init_addr = 5'd1; init_data = 32'd99;
            end
            if (mode == 1 && k == 2) begin
                start = 1'b0; init_we = 1'b0;
            end
            if (mode == 2 && k == 2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
                chk({tag, "_abort_done"}, 32'(done), 32'd0);
                model_reset();
                return;
            end
        end
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd5);
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic op(input string tag, input int r1, input int r2, input int rdst, input int o,
                      input bit rw, input bit mw, input bit mr);
        do_op(tag, r1, r2, rdst, o, rw, mw, mr, 0, 1'b0, 0, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding command.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk({e.tag, "_dout"}, dout, e.dout);
                chk({e.tag, "_latency"}, 32'(cyc - e.issue), 32'd4);
`ifdef SMALLCKT_ALU_FLAGS_EN
                chk({e.tag, "_flags"}, 32'(flags), 32'(e.flags));
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        scramble();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dout", dout, 32'd0);
`ifdef SMALLCKT_ALU_FLAGS_EN
        chk("reset_flags", 32'(flags), 32'd0);
`endif
        reset = 1'b0;

        init_write(1, 32'd7);
        init_write(2, 32'd5);
        op("add", 1, 2, 3, 0, 1, 0, 0);
        op("rd_r3", 3, 0, 0, 3, 0, 0, 0);
        op("sub", 2, 1, 5, 1, 1, 0, 0);
        op("slt", 5, 1, 6, 8, 1, 0, 0);
        op("sltu", 5, 1, 7, 9, 1, 0, 0);
        op("rd_r6", 6, 0, 0, 3, 0, 0, 0);
        op("rd_r7", 7, 0, 0, 3, 0, 0, 0);
        op("store", 1, 2, 0, 0, 0, 1, 0);
        op("load", 1, 0, 4, 0, 1, 0, 1);
        op("rd_r4", 4, 0, 0, 3, 0, 0, 0);
        op("ld_st", 1, 3, 0, 0, 0, 1, 1);
        op("reload", 1, 0, 0, 0, 0, 0, 1);
        do_op("poke", 1, 2, 8, 4, 1, 0, 0, 1, 1'b0, 0, 32'd0);
        op("rd_r1", 1, 0, 0, 3, 0, 0, 0);
        op("wr_r0", 1, 2, 0, 0, 1, 0, 0);
        op("rd_r0", 0, 0, 0, 3, 0, 0, 0);
        do_op("init_start", 9, 2, 10, 0, 1, 0, 0, 0, 1'b1, 9, 32'd100);
        op("rd_r10", 10, 0, 0, 3, 0, 0, 0);
        do_op("abort", 2, 1, 8, 0, 1, 1, 0, 2, 1'b0, 0, 32'd0);
        op("post_r8", 8, 0, 0, 3, 0, 0, 0);
        init_write(1, 32'd7);
        op("post_mem", 1, 0, 0, 0, 0, 0, 1);
        op("sub_zero", 1, 1, 0, 1, 0, 0, 0);
        init_write(11, 32'h7FFF_FFFF);
        init_write(12, 32'd1);
        op("add_ovf", 11, 12, 0, 0, 0, 0, 0);
        op("sub_ovf", 12, 11, 0, 1, 0, 0, 0);

        for (int r = 1; r < 32; r++)
            init_write(r, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom);
        for (int n = 0; n < 80; n++) begin
            string tag;
            tag = $sformatf("rnd%0d", n);
            do_op(tag, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom), 0,
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 31), $urandom);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
